// File: rtl/dmem_block_memory.sv
// dmem_block_memory: block-granular backing store for the D-cache with programmable
// read/write latency and single-cycle completion pulses.
`ifndef DMEM_BLOCK_ADDR_SIZE
`define DMEM_BLOCK_ADDR_SIZE 10
`endif
`ifndef DBLOCK_SIZE_BITS
`define DBLOCK_SIZE_BITS 128
`endif
module dmem_block_memory #(
  parameter int ADDR_W        = `DMEM_BLOCK_ADDR_SIZE,
  parameter int BLOCK_W       = `DBLOCK_SIZE_BITS,
  parameter int DEPTH         = 256,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               memRen,
  input  logic               memWen,
  input  logic [ADDR_W-1:0]  BlockAddr,
  input  logic [BLOCK_W-1:0] memDin,
  output logic [BLOCK_W-1:0] memDout,
  output logic               memReadReady,
  output logic               memWriteDone,
  output logic               memBusy
);
  localparam int MAX_L = READ_LATENCY > WRITE_LATENCY ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W = $clog2(MAX_L + 1);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, DONE} state_t;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   addr_q, addr_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic [BLOCK_W-1:0] dout_q;
  logic               rr_q, rr_d, wd_q, wd_d;
  logic [BLOCK_W-1:0] mem_q [DEPTH] = '{default: '0};
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rr_d    = 1'b0;
    wd_d    = 1'b0;
    case (state_q)
      IDLE: if (memRen ^ memWen) begin
        addr_d  = BlockAddr[IDX_W-1:0];
        data_d  = memWen ? memDin : data_q;
        cnt_d   = memRen ? CNT_W'(READ_LATENCY - 1) : CNT_W'(WRITE_LATENCY - 1);
        state_d = memRen ? READ_WAIT : WRITE_WAIT;
      end
      READ_WAIT: begin
        // a dropped request aborts even on the final wait cycle
        state_d = !memRen ? IDLE : (cnt_q == '0 ? DONE : READ_WAIT);
        cnt_d   = memRen && cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
        rr_d    = memRen && cnt_q == '0;
      end
      WRITE_WAIT: begin
        state_d = !memWen ? IDLE : (cnt_q == '0 ? DONE : WRITE_WAIT);
        cnt_d   = memWen && cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
        wd_d    = memWen && cnt_q == '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rr_q    <= 1'b0;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
    end
  end
  // array contents survive reset; only the in-flight write is dropped
  always_ff @(posedge clock) begin
    if (wd_d && !reset) mem_q[addr_q] <= data_q;
    if (reset) dout_q <= '0;
    else if (rr_d) dout_q <= mem_q[addr_q];
  end
  assign memDout      = dout_q;
  assign memReadReady = rr_q;
  assign memWriteDone = wd_q;
  assign memBusy      = state_q != IDLE;
endmodule

// File: tb/tb_dmem_block_memory.sv
// tb_dmem_block_memory: directed table plus randomized transactions checked against
// an array model of the memory and a cycle-count model of the latency.
module tb_dmem_block_memory;
  logic clock = 1'b0, reset = 1'b1, memRen = 1'b0, memWen = 1'b0;
  logic [9:0] BlockAddr = '0;
  logic [127:0] memDin = '0;
  logic [127:0] dout1, dout2, dout;
  logic rr1, rr2, wd1, wd2, busy1, busy2, rr, wd, busy;
  bit sel = 1'b0;
  int checks = 0, failures = 0;
  logic [127:0] mem_m [2][256];
  logic [127:0] dout_m [2];
  always #5 clock = ~clock;
  dmem_block_memory #(.ADDR_W(10), .BLOCK_W(128), .DEPTH(256), .READ_LATENCY(4), .WRITE_LATENCY(4)) dut (
    .clock(clock), .reset(reset), .memRen(memRen & !sel), .memWen(memWen & !sel),
    .BlockAddr(BlockAddr), .memDin(memDin), .memDout(dout1),
    .memReadReady(rr1), .memWriteDone(wd1), .memBusy(busy1));
  dmem_block_memory #(.ADDR_W(10), .BLOCK_W(128), .DEPTH(256), .READ_LATENCY(1), .WRITE_LATENCY(2)) dut_fast (
    .clock(clock), .reset(reset), .memRen(memRen & sel), .memWen(memWen & sel),
    .BlockAddr(BlockAddr), .memDin(memDin), .memDout(dout2),
    .memReadReady(rr2), .memWriteDone(wd2), .memBusy(busy2));
  assign dout = sel ? dout2 : dout1;
  assign rr   = sel ? rr2 : rr1;
  assign wd   = sel ? wd2 : wd1;
  assign busy = sel ? busy2 : busy1;
  typedef struct {
    bit           wr;
    logic [9:0]   addr;
    logic [127:0] data;
    int           abort_at;
    logic [127:0] exp_rd;
  } vec_t;
  vec_t tbl [9];
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  // abort_at=k drops the request right after edge E0+k; -1 means run to completion
  task automatic xact(input bit wr, input logic [9:0] a, input logic [127:0] d,
                      input int abort_at, input logic [127:0] exp_rd, input bit use_exp);
    int lat;
    lat = wr ? (sel ? 2 : 4) : (sel ? 1 : 4);
    memRen = !wr; memWen = wr; BlockAddr = a; memDin = d;
    tick();
    chk("busy_after_accept", busy, 1'b1);
    BlockAddr = 10'($urandom);
    memDin = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 1; k <= lat; k++) begin
      if (k - 1 == abort_at) begin
        memRen = 1'b0; memWen = 1'b0;
        tick();
        chk("abort_busy", busy, 1'b0);
        chk("abort_pulses", {rr, wd}, 2'b00);
        chk("abort_dout", dout, dout_m[sel]);
        return;
      end
      tick();
      chk(wr ? "write_done" : "read_ready", wr ? wd : rr, k == lat);
      chk("other_pulse", wr ? rr : wd, 1'b0);
      chk("busy_wait", busy, 1'b1);
    end
    if (wr) mem_m[sel][a[7:0]] = d;
    else dout_m[sel] = use_exp ? exp_rd : mem_m[sel][a[7:0]];
    chk("dout_at_pulse", dout, dout_m[sel]);
    tick();
    chk("busy_after_done", busy, 1'b0);
    chk("pulses_after_done", {rr, wd}, 2'b00);
    chk("dout_hold", dout, dout_m[sel]);
    memRen = 1'b0; memWen = 1'b0;
  endtask
  initial begin
    logic [127:0] d1, d2, d3, aa;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) mem_m[s][i] = '0;
      dout_m[s] = '0;
    end
    d1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    d2 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    d3 = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
    aa = {16{8'hAA}};
    tbl[0] = '{1'b1, 10'h005, d1, -1, '0};
    tbl[1] = '{1'b0, 10'h005, '0, -1, d1};
    tbl[2] = '{1'b1, 10'h00B, aa, -1, '0};
    tbl[3] = '{1'b1, 10'h00A, d2, -1, '0};
    tbl[4] = '{1'b0, 10'h00B, '0, -1, aa};
    tbl[5] = '{1'b0, 10'h00A, '0, -1, d2};
    tbl[6] = '{1'b1, 10'h003, d3, 2, '0};
    tbl[7] = '{1'b0, 10'h003, '0, -1, '0};
    tbl[8] = '{1'b0, 10'h105, '0, -1, d1};
    tick();
    tick();
    chk("reset_dout", dout1, '0);
    chk("reset_pulses", {rr1, wd1, rr2, wd2}, 4'b0);
    chk("reset_busy", {busy1, busy2}, 2'b0);
    reset = 1'b0;
    for (int i = 0; i < 9; i++)
      xact(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].abort_at, tbl[i].exp_rd, !tbl[i].wr);
    memRen = 1'b1; memWen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("both_req_busy", busy, 1'b0);
      chk("both_req_pulses", {rr, wd}, 2'b00);
    end
    memRen = 1'b0; memWen = 1'b0;
    tick();
    for (int i = 0; i < 60; i++) begin
      bit w;
      logic [9:0] a;
      int ab;
      w = 1'($urandom_range(0, 1));
      a = 10'($urandom_range(0, 1023)) & 10'h30F;
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
      xact(w, a, {$urandom, $urandom, $urandom, $urandom}, ab, '0, 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end
    memRen = 1'b1; BlockAddr = 10'h005;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; memRen = 1'b0;
    dout_m[0] = '0;
    chk("midreset_busy", busy1, 1'b0);
    chk("midreset_dout", dout1, '0);
    chk("midreset_ready", rr1, 1'b0);
    tick();
    chk("midreset_no_late_ready", rr1, 1'b0);
    sel = 1'b1;
    xact(1'b1, 10'h007, d2, -1, '0, 1'b0);
    xact(1'b0, 10'h007, '0, -1, d2, 1'b1);
    xact(1'b0, 10'h005, '0, -1, '0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_block_memory.md
# dmem_block_memory

Block-granular main data memory behind `dcache_controller`. It consumes the controller's `memRen`/`memWen`/`BlockAddr`/`memDin` requests and returns whole cache blocks on `memDout`. It signals completion with the single-cycle pulses `memReadReady`/`memWriteDone` after a programmable latency. It is the backing store for all D-cache refills and dirty write-backs, in both simulation and synthesis.

## Interface
- `ADDR_W`, default `` `DMEM_BLOCK_ADDR_SIZE ``: block address width.
- `BLOCK_W`, default `` `DBLOCK_SIZE_BITS `` (128): block width in bits.
- `DEPTH`, default 256: number of blocks stored. The array is indexed by `BlockAddr[$clog2(DEPTH)-1:0]`; upper address bits are ignored.
- `READ_LATENCY`, default 4: cycles from read accept to `memReadReady`. Legal range is ≥1.
- `WRITE_LATENCY`, default 4: cycles from write accept to `memWriteDone`. Legal range is ≥1.

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `memRen` in 1: read request, level, held by the requester until `memReadReady`.
- `memWen` in 1: write request, level, held by the requester until `memWriteDone`.
- `BlockAddr` in `ADDR_W`: block address.
- `memDin` in `BLOCK_W`: write data.
- `memDout` out `BLOCK_W`: read data, registered.
- `memReadReady` out 1: one-cycle read-complete pulse, registered.
- `memWriteDone` out 1: one-cycle write-complete pulse, registered.
- `memBusy` out 1: high in any state other than IDLE.

## Operation
- **States:** IDLE, READ_WAIT, WRITE_WAIT, DONE. The block holds a down-counter `lat_cnt` of width `$clog2(max(READ_LATENCY, WRITE_LATENCY)+1)`.
- **IDLE:**
  - `memRen && !memWen`: capture `BlockAddr`, set `lat_cnt = READ_LATENCY-1`, go to READ_WAIT.
  - `memWen && !memRen`: capture `BlockAddr` and `memDin`, set `lat_cnt = WRITE_LATENCY-1`, go to WRITE_WAIT.
  - Both or neither high: stay in IDLE. A simultaneous request is ignored and no pulse is produced.
- **READ_WAIT:**
  - `lat_cnt != 0`: decrement.
  - `lat_cnt == 0`: load `memDout` from the array at the captured address, assert `memReadReady`, go to DONE.
- **WRITE_WAIT:**
  - `lat_cnt != 0`: decrement.
  - `lat_cnt == 0`: write the captured data into the array, assert `memWriteDone`, go to DONE.
- **DONE:** lasts one cycle. Both pulses deassert, requests are not sampled (the requester's request is still high here), then go to IDLE.
- **Abort:** if the active request input (`memRen` in READ_WAIT, `memWen` in WRITE_WAIT) is low at a clock edge, go to IDLE.
  - No array write is performed.
  - `memDout` is unchanged.
  - No pulse is produced.
- **Captured operands:** address and data are captured at accept. Changes on `BlockAddr`/`memDin` during WAIT have no effect.
- **`memDout` hold:** `memDout` holds its last read value until the next completed read. The controller samples it in the cycle after `memReadReady`, so it must stay stable then.
- **Array contents:**
  - Zero at time 0.
  - Not altered by `reset`.
  - Write is full-block; no byte enables.

## Timing
- **Reset:** `reset` high at an edge forces state IDLE, `lat_cnt=0`, `memDout=0`, `memReadReady=0`, `memWriteDone=0`, `memBusy=0`. This applies mid-operation too; a pending write is dropped.
- **Latency:** request sampled at edge E0 → pulse is high during the cycle after edge E0+L, where L is the latency parameter. The state is back in IDLE after edge E0+L+1.
- **Next request:** the earliest next accept is edge E0+L+2. This matches the controller's WRITEBACK→MEMREAD sequence: `memWen` is still high in the DONE cycle, then `memRen` is high the following cycle.
- **Pulse width:** `memReadReady`/`memWriteDone` are exactly one cycle wide and never high together.
- **`memBusy`:** high from the cycle after accept through the DONE cycle.

## Test plan
- **Reset:** reset asserted for 2 cycles → all outputs 0, `memBusy=0`.
- **Write then read:** `memWen`, addr 0x05, data 0x1111_2222_3333_4444_5555_6666_7777_8888, L=4 → `memWriteDone` one cycle, 5 cycles after accept. Then `memRen` at addr 0x05 → `memReadReady` 5 cycles after accept with `memDout` equal to that data, and `memDout` still equal one cycle later.
- **Back-to-back:** write-back to 0x0A, then read of 0x0B (preloaded 0xAA..AA) with `memRen` asserted in the cycle right after DONE → read accepted, returns 0xAA..AA, 0x0A holds the new data.
- **Abort:** `memWen` to 0x03 is dropped after 2 cycles of WRITE_WAIT → no `memWriteDone`, and a later read of 0x03 returns its old value (0).
- **Illegal request:** `memRen` and `memWen` both high in IDLE for 3 cycles → stays in IDLE, no pulses.
- **Reset mid-read:** reset asserted in cycle 2 of READ_WAIT → IDLE next cycle, `memDout=0`, no `memReadReady`. A subsequent read with READ_LATENCY=1 → ready 2 cycles after accept.
